// File: rtl/conv_pkg.sv
// Shared types and defaults for the convolution datapath (Hadamard unit and
// adder-tree accumulator).
package conv_pkg;

  localparam int DEFAULT_WIDTH    = 32;
  localparam int DEFAULT_SIZE     = 9;
  localparam int DEFAULT_CHANNELS = 3;

  typedef logic [DEFAULT_WIDTH-1:0] word_t;
  typedef word_t [DEFAULT_SIZE-1:0] vec_t;

  // Number of leaves once the product vector is padded to a power of two.
  function automatic int tree_width(input int size);
    return 1 << $clog2(size);
  endfunction

endpackage

// File: rtl/adder_tree_accumulator_if.sv
// Product-vector input and result output handshake of the adder-tree accumulator.
interface adder_tree_accumulator_if #(
  parameter int WIDTH = conv_pkg::DEFAULT_WIDTH,
  parameter int SIZE  = conv_pkg::DEFAULT_SIZE
);

  logic [SIZE-1:0][WIDTH-1:0] din;
  logic                       in_valid;
  logic                       in_ready;
  logic                       clear;
  logic [WIDTH-1:0]           dout;
  logic                       out_valid;
  logic                       out_ready;

  modport master (
    output din, in_valid, clear, out_ready,
    input  in_ready, dout, out_valid
  );

  modport slave (
    input  din, in_valid, clear, out_ready,
    output in_ready, dout, out_valid
  );

endinterface

// File: rtl/adder_tree_accumulator_tree.sv
// Registered binary adder tree: SIZE words reduced to one sum in $clog2(SIZE)
// enabled cycles, one vector per cycle, modulo 2^WIDTH.
module pipelined_adder_tree
  import conv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SIZE  = DEFAULT_SIZE
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       clear,
  input  logic [SIZE-1:0][WIDTH-1:0] din,
  input  logic                       in_valid,
  output logic [WIDTH-1:0]           sum,
  output logic                       sum_valid
);

  localparam int LEVELS = $clog2(SIZE);
  localparam int PAD    = tree_width(SIZE);

  logic [PAD-1:0][WIDTH-1:0] padded;

  // NOTE: give every always_comb output a full default first so no latch is inferred.
  always_comb begin
    padded            = '0;
    padded[SIZE-1:0]  = din;
  end

  for (genvar l = 0; l < LEVELS; l++) begin : g_level
    localparam int N = PAD >> (l + 1);

    logic [2*N-1:0][WIDTH-1:0] d;
    logic                      v_in;
    logic [N-1:0][WIDTH-1:0]   q;
    logic                      v;

    if (l == 0) begin : g_first
      assign d    = padded;
      assign v_in = in_valid;
    end else begin : g_next
      assign d    = g_level[l-1].q;
      assign v_in = g_level[l-1].v;
    end

    // NOTE: non-blocking assignments so each level captures the previous level's
    // pre-edge value; data registers are reset too so nothing powers up as X.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q <= '0;
        v <= 1'b0;
      end else if (clear) begin
        v <= 1'b0;
      end else if (en) begin
        v <= v_in;
        for (int i = 0; i < N; i++) begin
          q[i] <= d[2*i] + d[2*i+1];
        end
      end
    end
  end

  assign sum       = g_level[LEVELS-1].q[0];
  assign sum_valid = g_level[LEVELS-1].v;

endmodule

// File: rtl/adder_tree_accumulator.sv
// Reduces each product vector through the adder tree, sums CHANNELS consecutive
// results into one output pixel and holds it on a valid/ready output.
module adder_tree_accumulator
  import conv_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int SIZE     = DEFAULT_SIZE,
  parameter int CHANNELS = DEFAULT_CHANNELS
) (
  input  logic                      clk,
  input  logic                      rst_n,
  adder_tree_accumulator_if.slave   bus
);

  localparam int              CW   = (CHANNELS < 2) ? 1 : $clog2(CHANNELS + 1);
  localparam logic [CW-1:0]   LAST = CW'(CHANNELS - 1);

  logic             en;
  logic [WIDTH-1:0] tree_sum;
  logic             tree_valid;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    ch_cnt;
  logic [WIDTH-1:0] sum_next;
  logic [WIDTH-1:0] dout_q;
  logic             out_valid_q;

  // The whole pipeline advances only when the output register can take a result.
  assign en           = !out_valid_q || bus.out_ready;
  assign bus.in_ready = en;
  assign bus.dout      = dout_q;
  assign bus.out_valid = out_valid_q;

  pipelined_adder_tree #(
    .WIDTH (WIDTH),
    .SIZE  (SIZE)
  ) u_tree (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .clear     (bus.clear),
    .din       (bus.din),
    .in_valid  (bus.in_valid),
    .sum       (tree_sum),
    .sum_valid (tree_valid)
  );

  // Channel 0 starts a fresh pixel, so the stale accumulator is ignored.
  assign sum_next = tree_sum + ((ch_cnt == '0) ? {WIDTH{1'b0}} : acc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc         <= '0;
      ch_cnt      <= '0;
      dout_q      <= '0;
      out_valid_q <= 1'b0;
    end else if (bus.clear) begin
      acc         <= '0;
      ch_cnt      <= '0;
      out_valid_q <= 1'b0;
    end else if (en) begin
      // Enabled with out_valid set means the consumer took dout this cycle.
      out_valid_q <= 1'b0;
      if (tree_valid) begin
        if (ch_cnt == LAST) begin
          dout_q      <= sum_next;
          out_valid_q <= 1'b1;
          acc         <= '0;
          ch_cnt      <= '0;
        end else begin
          acc    <= sum_next;
          ch_cnt <= ch_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_adder_tree_accumulator.sv
// Directed bench for adder_tree_accumulator: one instance with CHANNELS=1 and
// one with CHANNELS=3, sharing clock and reset.
module tb_adder_tree_accumulator;

  localparam int W = 32;
  localparam int S = 9;

  typedef logic [S-1:0][W-1:0] tvec_t;
  typedef struct {
    tvec_t        din;
    logic [W-1:0] exp;
    string        name;
  } vec_rec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  adder_tree_accumulator_if #(.WIDTH(W), .SIZE(S)) bus1 ();
  adder_tree_accumulator_if #(.WIDTH(W), .SIZE(S)) bus3 ();

  adder_tree_accumulator #(.WIDTH(W), .SIZE(S), .CHANNELS(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  adder_tree_accumulator #(.WIDTH(W), .SIZE(S), .CHANNELS(3)) u_dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic tvec_t fill(input logic [W-1:0] v);
    tvec_t r;
    for (int i = 0; i < S; i++) r[i] = v;
    return r;
  endfunction

  function automatic tvec_t ramp();
    tvec_t r;
    for (int i = 0; i < S; i++) r[i] = W'(i + 1);
    return r;
  endfunction

  // One vector into the CHANNELS=1 instance; measures cycles to out_valid.
  task automatic run_ch1(input tvec_t d, input logic [W-1:0] exp, input string name);
    int lat;
    bus1.din      = d;
    bus1.in_valid = 1'b1;
    step();
    bus1.in_valid = 1'b0;
    lat = 1;
    while (!bus1.out_valid && lat < 20) begin
      step();
      lat++;
    end
    check({name, " latency"}, W'(lat), W'(5));
    check({name, " dout"}, bus1.dout, exp);
    step();
    check({name, " single cycle"}, W'(bus1.out_valid), W'(0));
  endtask

  vec_rec_t     tbl [4];
  tvec_t        bp  [4];
  logic [W-1:0] got [$];
  logic [W-1:0] bp_exp [4];

  initial begin
    tvec_t t;
    int    n;
    logic  seen;

    bus1.din = '0; bus1.in_valid = 1'b0; bus1.clear = 1'b0; bus1.out_ready = 1'b1;
    bus3.din = '0; bus3.in_valid = 1'b0; bus3.clear = 1'b0; bus3.out_ready = 1'b1;

    tbl[0].din = ramp();              tbl[0].exp = 32'd45;         tbl[0].name = "ramp1to9";
    tbl[1].din = fill(32'hFFFFFFFF);  tbl[1].exp = 32'hFFFFFFF7;   tbl[1].name = "wrap_ones";
    t = '0; t[0] = 32'h80000000; t[1] = 32'h80000000;
    tbl[2].din = t;                   tbl[2].exp = 32'd0;          tbl[2].name = "wrap_msb";
    t = '0; t[0] = -32'sd5; t[1] = 32'd3; t[8] = 32'd10;
    tbl[3].din = t;                   tbl[3].exp = 32'd8;          tbl[3].name = "signed_mix";

    // Reset state
    repeat (3) step();
    rst_n = 1'b1;
    step();
    check("rst out_valid1", W'(bus1.out_valid), W'(0));
    check("rst dout1",      bus1.dout,          W'(0));
    check("rst in_ready1",  W'(bus1.in_ready),  W'(1));
    check("rst out_valid3", W'(bus3.out_valid), W'(0));
    check("rst dout3",      bus3.dout,          W'(0));

    // Single-channel reductions, latency and wrap
    for (int i = 0; i < 4; i++) run_ch1(tbl[i].din, tbl[i].exp, tbl[i].name);

    // Three channels back to back: 18 + 27 + 36 = 81, out_valid only after the last
    for (int k = 0; k < 10; k++) begin
      bus3.in_valid = (k < 3);
      bus3.din      = fill(W'(k + 2));
      step();
      check($sformatf("acc3 out_valid e%0d", k + 1), W'(bus3.out_valid), W'(k + 1 == 7));
      if (k + 1 == 7) check("acc3 dout", bus3.dout, W'(81));
    end

    // Backpressure: results 45, 9, 18, 0 with a 6-cycle stall on the first
    bp[0] = ramp(); bp[1] = fill(1); bp[2] = fill(2); bp[3] = tbl[2].din;
    bp_exp[0] = 45; bp_exp[1] = 9; bp_exp[2] = 18; bp_exp[3] = 0;
    for (int k = 0; k < 4; k++) begin
      bus1.din = bp[k]; bus1.in_valid = 1'b1;
      step();
    end
    bus1.in_valid = 1'b0;
    n = 0;
    while (!bus1.out_valid && n < 10) begin
      step();
      n++;
    end
    check("bp first valid", W'(bus1.out_valid), W'(1));
    bus1.out_ready = 1'b0;
    #1;
    for (int k = 0; k < 6; k++) begin
      check($sformatf("bp in_ready c%0d", k), W'(bus1.in_ready), W'(0));
      check($sformatf("bp dout hold c%0d", k), bus1.dout, W'(45));
      step();
    end
    check("bp still valid", W'(bus1.out_valid), W'(1));
    bus1.out_ready = 1'b1;
    #1;
    for (int k = 0; k < 20; k++) begin
      if (bus1.out_valid && bus1.out_ready) got.push_back(bus1.dout);
      step();
    end
    check("bp result count", W'(got.size()), W'(4));
    for (int i = 0; i < 4; i++)
      check($sformatf("bp result %0d", i), (i < got.size()) ? got[i] : 'x, bp_exp[i]);

    // Continuous stream with out_ready=1: out_valid stays high across results
    for (int k = 0; k < 10; k++) begin
      bus1.in_valid = (k < 4);
      bus1.din      = fill(W'(k + 1));
      step();
      check($sformatf("stream valid e%0d", k + 1), W'(bus1.out_valid),
            W'((k + 1 >= 5) && (k + 1 <= 8)));
      if ((k + 1 >= 5) && (k + 1 <= 8))
        check($sformatf("stream dout e%0d", k + 1), bus1.dout, W'(9 * (k + 1 - 4)));
    end

    // clear with two vectors in flight and one presented during clear
    bus3.in_valid = 1'b1;
    bus3.din = fill(5); step();
    bus3.din = fill(7); step();
    bus3.din = fill(9); bus3.clear = 1'b1; step();
    bus3.clear = 1'b0; bus3.in_valid = 1'b0;
    check("clear out_valid", W'(bus3.out_valid), W'(0));
    check("clear keeps dout", bus3.dout, W'(81));
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      seen |= bus3.out_valid;
    end
    check("clear no stale output", W'(seen), W'(0));
    bus3.din = fill(1); bus3.in_valid = 1'b1;
    repeat (3) step();
    bus3.in_valid = 1'b0;
    n = 0;
    while (!bus3.out_valid && n < 12) begin
      step();
      n++;
    end
    check("clear then 27", bus3.dout, W'(27));
    check("clear then valid", W'(bus3.out_valid), W'(1));
    step();

    // Reset after two channels have reached the accumulator
    bus3.in_valid = 1'b1;
    bus3.din = fill(5); step();
    bus3.din = fill(7); step();
    bus3.in_valid = 1'b0;
    repeat (6) step();
    rst_n = 1'b0;
    #2;
    check("rst mid out_valid", W'(bus3.out_valid), W'(0));
    check("rst mid dout", bus3.dout, W'(0));
    step();
    rst_n = 1'b1;
    step();
    bus3.din = fill(1); bus3.in_valid = 1'b1;
    repeat (3) step();
    bus3.in_valid = 1'b0;
    n = 0;
    seen = 1'b0;
    while (!bus3.out_valid && n < 12) begin
      step();
      n++;
    end
    check("rst then valid", W'(bus3.out_valid), W'(1));
    check("rst then 27", bus3.dout, W'(27));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/adder_tree_accumulator.md
Name: adder_tree_accumulator

Overview:
- Downstream neighbour of the Hadamard product unit.
- Takes the SIZE element-wise products of one kernel/patch pair and reduces them to one scalar through a registered binary adder tree.
- Accumulates CHANNELS consecutive scalars (one per input channel) into a single convolution output pixel.
- Presents that pixel on a valid/ready output interface with full-pipeline stall on backpressure.

Parameters:
- WIDTH, 32, bit width of each product and of the result.
- SIZE, 9, number of products per input vector (kernel window elements).
- CHANNELS, 3, input vectors summed per output; legal range 1..65535.
- LEVELS, $clog2(SIZE) (4 for SIZE=9), derived, adder-tree depth; not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  [SIZE-1:0][WIDTH-1:0]  products from the Hadamard unit.
- in_valid  input  1  din valid; driven from the Hadamard unit's mul_valid.
- in_ready  output  1  block can accept din this cycle.
- clear  input  1  synchronous flush of pipeline and channel count.
- dout  output  [WIDTH-1:0]  accumulated convolution result.
- out_valid  output  1  dout holds a completed result.
- out_ready  input  1  consumer accepts dout.

Behaviour:
- Reset (rst_n low, asynchronous): all tree-stage valid bits 0, all tree data registers 0, acc=0, ch_cnt=0, dout=0, out_valid=0. in_ready reads 1 one cycle after reset release.
- Advance enable: en = !out_valid || out_ready (combinational); in_ready = en.
- Transfer: din is accepted when in_valid && in_ready.
- Stall: when en=0, every pipeline register, acc, ch_cnt and dout hold their values. Bubbles are not compressed.
- Tree stage 0: din is zero-padded to 2^LEVELS elements. Each level adds adjacent pairs and registers the sums together with a valid bit.
- Tree latency and throughput: exactly LEVELS enabled cycles; one vector per cycle.
- Arithmetic: all additions are modulo 2^WIDTH (two's-complement wrap). There is no saturation and no width growth; signed and unsigned results are bit-identical.
- Accumulator stage (acts on an enabled cycle when the tree output is valid):
  - sum = tree_out + (ch_cnt==0 ? 0 : acc).
  - If ch_cnt == CHANNELS-1: dout <= sum, out_valid <= 1, ch_cnt <= 0, acc <= 0.
  - Otherwise: acc <= sum, ch_cnt <= ch_cnt+1.
- Latency: from acceptance of the last channel's vector to out_valid=1 is LEVELS+1 cycles with no stall (5 for defaults).
- Output handshake:
  - out_valid and dout stay stable until out_ready is high.
  - On out_valid && out_ready with no new completion in the same cycle, out_valid <= 0.
  - If a new completion coincides with out_ready, dout is overwritten with the new result and out_valid stays 1. No result is lost and none is duplicated.
- CHANNELS=1: every tree result goes directly to dout; acc is unused.
- clear (synchronous, priority over all other updates, ignores en): tree valid bits 0, ch_cnt 0, acc 0, out_valid 0. dout keeps its value. An input presented while clear=1 is discarded.
- Reset mid-operation: partial accumulation and in-flight vectors are discarded; the next accepted vector is treated as channel 0.
- ch_cnt width: $clog2(CHANNELS+1), minimum 1 bit.

Decomposition:
- Shared package conv_pkg holds:
  - Default WIDTH, SIZE and CHANNELS constants.
  - typedef word_t, logic [WIDTH-1:0].
  - typedef vec_t, word_t [SIZE-1:0], shared with the Hadamard unit's ports.
  - A function computing the padded tree width 2^$clog2(SIZE).
- One sub-module, pipelined_adder_tree:
  - Parameters WIDTH and SIZE.
  - Ports: clk, rst_n, en, clear, din, in_valid, sum, sum_valid.
  - Contains the LEVELS registered stages.
- The top module adds the channel counter, the accumulator and the output handshake.

Test Plan:
- CHANNELS=1, din = 1..9, out_ready=1 -> dout=45, out_valid high exactly 5 cycles after acceptance, for one cycle.
- CHANNELS=3, three back-to-back vectors each with all elements = 2, then 3, then 4 -> single dout=81, out_valid 5 cycles after the third vector; no output after the first two.
- Wrap: CHANNELS=1, all elements 32'hFFFFFFFF -> dout=32'hFFFFFFF7; elements {32'h80000000, 32'h80000000, rest 0} -> dout=0.
- Backpressure: CHANNELS=1, stream 4 vectors with sums 45, 9, 18, 0, out_ready=0 for 6 cycles after the first result -> in_ready=0 while out_valid && !out_ready; dout holds 45; after release, the results appear in order 45, 9, 18, 0 with no loss and no duplication.
- Simultaneous handshake: continuous input with out_ready=1 -> out_valid stays 1 over consecutive results and dout updates every CHANNELS cycles.
- Reset/clear mid-operation: CHANNELS=3, two vectors accepted, then clear (or rst_n pulse) -> out_valid=0 and ch_cnt=0; three subsequent vectors each with all elements = 1 -> dout=27, with no contribution from the flushed vectors.
